// File: rtl/ps2_frame_transmitter.sv
// PS/2-style frame transmitter: start, 8 data bits LSB first, odd parity, stop,
// followed by a mandatory idle-high gap before the next request is accepted.
module ps2_frame_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned IDLE_BITS    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       send,
    input  logic       err_inject,
    output logic       ready,
    output logic       busy,
    output logic       data,
    output logic       serial_clk,
    output logic       frame_done
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF     = CLKS_PER_BIT / 2;
    localparam int unsigned GAP_LEN  = IDLE_BITS * CLKS_PER_BIT;
    localparam int unsigned GAP_W    = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam int unsigned GAP_LAST = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       bit_idx;
    logic [7:0]       shreg;
    logic             parity_bit;
    logic [GAP_W-1:0] gap_cnt;
    logic             bit_end;

    assign cnt_inc = cnt + CNT_W'(1);
    assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Outputs are loaded with the value for the cycle that follows each edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            gap_cnt    <= '0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            data       <= 1'b1;
            serial_clk <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    ready <= 1'b1;
                    if (send && ready) begin
                        state      <= S_START;
                        ready      <= 1'b0;
                        busy       <= 1'b1;
                        cnt        <= '0;
                        bit_idx    <= '0;
                        shreg      <= scan_code;
                        parity_bit <= (~^scan_code) ^ err_inject;
                        data       <= 1'b0;
                        serial_clk <= 1'b1;
                    end
                end
                S_START, S_DATA, S_PARITY, S_STOP: begin
                    if (!bit_end) begin
                        cnt        <= cnt_inc;
                        serial_clk <= (cnt_inc < CNT_W'(HALF));
                        frame_done <= (state == S_STOP) &&
                                      (cnt_inc == CNT_W'(CLKS_PER_BIT - 1));
                    end else begin
                        cnt        <= '0;
                        serial_clk <= 1'b1;
                        case (state)
                            S_START: begin
                                state   <= S_DATA;
                                bit_idx <= bit_idx + 4'd1;
                                data    <= shreg[0];
                                shreg   <= {1'b0, shreg[7:1]};
                            end
                            S_DATA: begin
                                bit_idx <= bit_idx + 4'd1;
                                if (bit_idx == 4'd8) begin
                                    state <= S_PARITY;
                                    data  <= parity_bit;
                                end else begin
                                    data  <= shreg[0];
                                    shreg <= {1'b0, shreg[7:1]};
                                end
                            end
                            S_PARITY: begin
                                state   <= S_STOP;
                                bit_idx <= bit_idx + 4'd1;
                                data    <= 1'b1;
                            end
                            default: begin
                                bit_idx <= '0;
                                data    <= 1'b1;
                                gap_cnt <= '0;
                                if (GAP_LEN == 0) begin
                                    state <= S_IDLE;
                                    ready <= 1'b1;
                                    busy  <= 1'b0;
                                end else begin
                                    state <= S_GAP;
                                end
                            end
                        endcase
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        state   <= S_IDLE;
                        gap_cnt <= '0;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_frame_transmitter.sv
// Directed bench for ps2_frame_transmitter: table of frames plus reset and
// narrow-bit-period sequences.
module tb_ps2_frame_transmitter;

    localparam int unsigned N  = 10;
    localparam int unsigned IB = 2;
    localparam int unsigned G  = IB * N;
    localparam int unsigned FL = 11 * N;
    localparam int unsigned N4 = 4;
    localparam int unsigned G4 = 2 * N4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, send, err_inject;
    logic [7:0] scan_code;
    logic       ready, busy, data, serial_clk, frame_done;

    logic       reset4, send4, err4;
    logic [7:0] code4;
    logic       ready4, busy4, data4, sclk4, fd4;

    int errors = 0;
    int checks = 0;

    ps2_frame_transmitter #(.CLKS_PER_BIT(N), .IDLE_BITS(IB)) dut (
        .clk(clk), .reset(reset), .scan_code(scan_code), .send(send),
        .err_inject(err_inject), .ready(ready), .busy(busy), .data(data),
        .serial_clk(serial_clk), .frame_done(frame_done)
    );

    ps2_frame_transmitter #(.CLKS_PER_BIT(N4), .IDLE_BITS(2)) dut4 (
        .clk(clk), .reset(reset4), .scan_code(code4), .send(send4),
        .err_inject(err4), .ready(ready4), .busy(busy4), .data(data4),
        .serial_clk(sclk4), .frame_done(fd4)
    );

    typedef struct {
        logic [7:0]  code;
        logic        err;
        logic        hold;
        logic        pulse;
        logic [10:0] bits;   // bit i = line value during frame bit i
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Sends one frame on the N=10 instance and checks every cycle through the gap.
    task automatic run_frame(input vec_t v);
        int k;
        scan_code  = v.code;
        err_inject = v.err;
        send       = 1'b1;
        k = 0;
        while (!ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("accept_timeout", ready, 1'b1);
        if (!ready) return;
        @(negedge clk);
        for (int t = 0; t < int'(FL + G); t++) begin
            if (t > 0) @(negedge clk);
            chk("data", data, (t < int'(FL)) ? v.bits[t / N] : 1'b1);
            chk("serial_clk", serial_clk, (t < int'(FL)) ? ((t % N) < N / 2) : 1'b1);
            chk("frame_done", frame_done, t == int'(FL) - 1);
            chk("busy", busy, 1'b1);
            chk("ready", ready, 1'b0);
            if (t == 0) begin
                scan_code  = ~v.code;
                err_inject = ~v.err;
                if (!v.hold) send = 1'b0;
            end
            if (t == 5) scan_code = 8'h55;
            if (v.pulse) send = (t == 40) || (t == 120);
        end
        @(negedge clk);
        chk("ready_rise", ready, 1'b1);
        chk("busy_fall", busy, 1'b0);
        chk("gap_end_data", data, 1'b1);
        chk("gap_end_sclk", serial_clk, 1'b1);
    endtask

    initial begin
        logic [10:0] bits4;
        logic        prev;

        vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b0, 11'b1_0_00011100_0};
        vecs[1] = '{8'hF0, 1'b0, 1'b1, 1'b0, 11'b1_1_11110000_0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 11'b1_1_00000000_0};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, 11'b1_1_11111111_0};
        vecs[4] = '{8'h1C, 1'b1, 1'b0, 1'b0, 11'b1_1_00011100_0};
        vecs[5] = '{8'hA5, 1'b0, 1'b0, 1'b0, 11'b1_1_10100101_0};
        vecs[6] = '{8'h5A, 1'b0, 1'b0, 1'b1, 11'b1_1_01011010_0};

        reset = 1'b1; send = 1'b0; err_inject = 1'b0; scan_code = 8'h00;
        reset4 = 1'b1; send4 = 1'b0; err4 = 1'b0; code4 = 8'h00;

        @(negedge clk);
        chk("rst_data", data, 1'b1);
        chk("rst_sclk", serial_clk, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_ready", ready, 1'b0);
        reset = 1'b0; reset4 = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", ready, 1'b1);
        chk("busy_after_rst", busy, 1'b0);

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i]);
            if (vecs[i].pulse) begin
                send = 1'b0;
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    chk("no_second_frame_busy", busy, 1'b0);
                    chk("no_second_frame_data", data, 1'b1);
                end
            end
        end

        // Reset in the middle of a frame.
        scan_code = 8'h1C; err_inject = 1'b0; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        for (int t = 1; t <= 55; t++) @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_data", data, 1'b1);
        chk("midrst_sclk", serial_clk, 1'b1);
        chk("midrst_ready", ready, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_frame_done", frame_done, 1'b0);
        @(negedge clk);
        chk("midrst_ready_back", ready, 1'b1);
        chk("midrst_no_done", frame_done, 1'b0);
        run_frame(vecs[0]);

        // Reset and send on the same edge: the request is dropped.
        send = 1'b1; reset = 1'b1;
        @(negedge clk);
        chk("rst_send_busy", busy, 1'b0);
        chk("rst_send_ready", ready, 1'b0);
        reset = 1'b0; send = 1'b0;
        @(negedge clk);
        chk("rst_send_ready_back", ready, 1'b1);
        chk("rst_send_busy2", busy, 1'b0);
        @(negedge clk);
        chk("rst_send_dropped", busy, 1'b0);

        // Narrow bit period: SERIAL_CLK 1,1,0,0 and DATA moves only at bit edges.
        bits4 = 11'b1_1_10100101_0;
        code4 = 8'hA5; send4 = 1'b1;
        chk("n4_ready", ready4, 1'b1);
        @(negedge clk);
        send4 = 1'b0; code4 = 8'h00;
        prev = 1'b1;
        for (int t = 0; t < int'(11 * N4 + G4); t++) begin
            if (t > 0) @(negedge clk);
            chk("n4_data", data4, (t < int'(11 * N4)) ? bits4[t / N4] : 1'b1);
            chk("n4_sclk", sclk4, (t < int'(11 * N4)) ? ((t % N4) < 2) : 1'b1);
            chk("n4_frame_done", fd4, t == int'(11 * N4) - 1);
            chk("n4_busy", busy4, 1'b1);
            if (t > 0 && (t % N4) != 0) chk("n4_data_stable", data4, prev);
            prev = data4;
        end
        @(negedge clk);
        chk("n4_ready_rise", ready4, 1'b1);
        chk("n4_busy_fall", busy4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
